// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage with a fixed-latency data memory and the MEM/WB register.
// Optional build macro MEM_RANGE_CHECK_EN adds an address-range fault check and the mem_fault_r port.
module memory_stage #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned MEM_LAT = 2,
    localparam int unsigned DATA_W = 16,
    localparam int unsigned REG_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic [REG_W-1:0]  reg_write_address_from_execute,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data_r,
    output logic              RegWrite_r,
    output logic [REG_W-1:0]  reg_write_address_to_writeback
`ifdef MEM_RANGE_CHECK_EN
   ,output logic              mem_fault_r
`endif
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [1:0]  LAST_CNT = 2'(MEM_LAT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [1:0]          cnt, cnt_next;
    logic [DATA_W-1:0]   wb_data_next;
    logic                reg_write_next;
    logic [REG_W-1:0]    reg_addr_next;
`ifdef MEM_RANGE_CHECK_EN
    logic                fault_next;
`endif

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   mem_addr_c;
    logic [DATA_W-1:0]   rd_data_c;
    logic                mem_op_c;
    logic                complete_c;
    logic                range_fault_c;
    logic                mem_we_c;

    assign mem_addr_c = alu_result[ADDR_W-1:0];
    assign rd_data_c  = mem[mem_addr_c];
    assign mem_op_c   = MemRead | MemWrite;
    assign complete_c = mem_op_c && (cnt == LAST_CNT);
    assign stall      = mem_op_c && (cnt != LAST_CNT);

`ifdef MEM_RANGE_CHECK_EN
    // Any set bit above the memory's address range is a fault.
    assign range_fault_c = |(alu_result >> ADDR_W);
`else
    // Upper address bits are ignored; addresses wrap modulo the depth.
    assign range_fault_c = 1'b0;
`endif

    // Stores commit only on the completion edge and never while reset is held.
    assign mem_we_c = complete_c && MemWrite && !range_fault_c && reset;

    // Data memory: no reset, contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_addr_c] <= store_data;
        end
    end

    // State, counter and MEM/WB register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                          <= IDLE;
            cnt                            <= 2'd0;
            wb_data_r                      <= '0;
            RegWrite_r                     <= 1'b0;
            reg_write_address_to_writeback <= '0;
`ifdef MEM_RANGE_CHECK_EN
            mem_fault_r                    <= 1'b0;
`endif
        end else begin
            state                          <= state_next;
            cnt                            <= cnt_next;
            wb_data_r                      <= wb_data_next;
            RegWrite_r                     <= reg_write_next;
            reg_write_address_to_writeback <= reg_addr_next;
`ifdef MEM_RANGE_CHECK_EN
            mem_fault_r                    <= fault_next;
`endif
        end
    end

    // Next state and next MEM/WB contents; the default is a bubble.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        wb_data_next   = '0;
        reg_write_next = 1'b0;
        reg_addr_next  = '0;
`ifdef MEM_RANGE_CHECK_EN
        fault_next     = 1'b0;
`endif

        if (!mem_op_c) begin
            // ALU result passes straight through; an abandoned access returns to IDLE.
            state_next     = IDLE;
            cnt_next       = 2'd0;
            wb_data_next   = alu_result;
            reg_write_next = RegWrite;
            reg_addr_next  = reg_write_address_from_execute;
        end else if (complete_c) begin
            state_next = IDLE;
            cnt_next   = 2'd0;
            if (range_fault_c) begin
`ifdef MEM_RANGE_CHECK_EN
                fault_next = 1'b1;
`endif
            end else begin
                // Store wins when both requests are high; the read is suppressed.
                wb_data_next   = MemWrite ? alu_result : rd_data_c;
                reg_write_next = RegWrite;
                reg_addr_next  = reg_write_address_from_execute;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = ACCESS;
                    cnt_next   = cnt + 2'd1;
                end
                ACCESS: begin
                    cnt_next = cnt + 2'd1;
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed checks of memory_stage at MEM_LAT 1..4 sharing one stimulus stream.
module tb_memory_stage;

    logic        clk;
    logic        reset;
    logic [15:0] alu_result;
    logic [15:0] store_data;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic [2:0]  reg_addr;

    logic        st_1, st_2, st_3, st_4;
    logic [15:0] wb_1, wb_2, wb_3, wb_4;
    logic        rw_1, rw_2, rw_3, rw_4;
    logic [2:0]  ad_1, ad_2, ad_3, ad_4;
`ifdef MEM_RANGE_CHECK_EN
    logic        fault_1, fault_2, fault_3, fault_4;
`endif

    int checks = 0;
    int errors = 0;

    memory_stage #(.ADDR_W(11), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset), .alu_result(alu_result), .store_data(store_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .reg_write_address_from_execute(reg_addr), .stall(st_1), .wb_data_r(wb_1),
        .RegWrite_r(rw_1), .reg_write_address_to_writeback(ad_1)
`ifdef MEM_RANGE_CHECK_EN
       ,.mem_fault_r(fault_1)
`endif
    );

    memory_stage #(.ADDR_W(11), .MEM_LAT(2)) u2 (
        .clk(clk), .reset(reset), .alu_result(alu_result), .store_data(store_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .reg_write_address_from_execute(reg_addr), .stall(st_2), .wb_data_r(wb_2),
        .RegWrite_r(rw_2), .reg_write_address_to_writeback(ad_2)
`ifdef MEM_RANGE_CHECK_EN
       ,.mem_fault_r(fault_2)
`endif
    );

    memory_stage #(.ADDR_W(11), .MEM_LAT(3)) u3 (
        .clk(clk), .reset(reset), .alu_result(alu_result), .store_data(store_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .reg_write_address_from_execute(reg_addr), .stall(st_3), .wb_data_r(wb_3),
        .RegWrite_r(rw_3), .reg_write_address_to_writeback(ad_3)
`ifdef MEM_RANGE_CHECK_EN
       ,.mem_fault_r(fault_3)
`endif
    );

    memory_stage #(.ADDR_W(11), .MEM_LAT(4)) u4 (
        .clk(clk), .reset(reset), .alu_result(alu_result), .store_data(store_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .reg_write_address_from_execute(reg_addr), .stall(st_4), .wb_data_r(wb_4),
        .RegWrite_r(rw_4), .reg_write_address_to_writeback(ad_4)
`ifdef MEM_RANGE_CHECK_EN
       ,.mem_fault_r(fault_4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge passes; we land on the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic mr, input logic mw, input logic rw,
                         input logic [15:0] alu, input logic [15:0] sd, input logic [2:0] ad);
        MemRead    = mr;
        MemWrite   = mw;
        RegWrite   = rw;
        alu_result = alu;
        store_data = sd;
        reg_addr   = ad;
        #1;
    endtask

    task automatic nop(input int n);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
        tick();
        chk("rst_wb2", wb_2, 16'h0);
        chk("rst_rw2", 16'(rw_2), 16'h0);
        chk("rst_ad2", 16'(ad_2), 16'h0);
        chk("rst_wb4", wb_4, 16'h0);
        reset = 1'b1;

        // ALU op passes through without stalling.
        drive(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0, 3'd5);
        chk("alu_st2", 16'(st_2), 16'h0);
        chk("alu_st4", 16'(st_4), 16'h0);
        tick();
        chk("alu_wb2", wb_2, 16'h1234);
        chk("alu_rw2", 16'(rw_2), 16'h1);
        chk("alu_ad2", 16'(ad_2), 16'h5);
        chk("alu_wb1", wb_1, 16'h1234);

        // Store then back-to-back load at MEM_LAT=2.
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 3'd0);
        chk("st_stall2", 16'(st_2), 16'h1);
        tick();
        chk("st_bub_rw2", 16'(rw_2), 16'h0);
        chk("st_bub_wb2", wb_2, 16'h0);
        chk("st_last_st2", 16'(st_2), 16'h0);
        tick();
        chk("st_done_wb2", wb_2, 16'h0010);
        chk("st_done_rw2", 16'(rw_2), 16'h0);
        drive(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0, 3'd3);
        chk("ld_stall2", 16'(st_2), 16'h1);
        tick();
        chk("ld_bub_rw2", 16'(rw_2), 16'h0);
        chk("ld_bub_ad2", 16'(ad_2), 16'h0);
        tick();
        chk("ld_wb2", wb_2, 16'hBEEF);
        chk("ld_rw2", 16'(rw_2), 16'h1);
        chk("ld_ad2", 16'(ad_2), 16'h3);
        nop(2);

        // MEM_LAT=4: store, then load with three bubbles.
        drive(1'b0, 1'b1, 1'b0, 16'h0030, 16'h4444, 3'd0);
        repeat (4) tick();
        chk("st4_wb", wb_4, 16'h0030);
        drive(1'b1, 1'b0, 1'b1, 16'h0030, 16'h0, 3'd6);
        chk("ld4_st_c0", 16'(st_4), 16'h1);
        tick();
        chk("ld4_rw_b1", 16'(rw_4), 16'h0);
        chk("ld4_st_c1", 16'(st_4), 16'h1);
        tick();
        chk("ld4_rw_b2", 16'(rw_4), 16'h0);
        chk("ld4_st_c2", 16'(st_4), 16'h1);
        tick();
        chk("ld4_rw_b3", 16'(rw_4), 16'h0);
        chk("ld4_st_c3", 16'(st_4), 16'h0);
        tick();
        chk("ld4_wb", wb_4, 16'h4444);
        chk("ld4_rw", 16'(rw_4), 16'h1);
        chk("ld4_ad", 16'(ad_4), 16'h6);
        nop(2);

        // MEM_LAT=3: reset in the middle of a store aborts it.
        drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h1111, 3'd0);
        repeat (3) tick();
        nop(2);
        drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'h00AA, 3'd7);
        tick();
        chk("ab_st3_cnt1", 16'(st_3), 16'h1);
        chk("ab_wb1_pre", wb_1, 16'h0020);
        chk("ab_rw1_pre", 16'(rw_1), 16'h1);
        chk("ab_ad1_pre", 16'(ad_1), 16'h7);
        reset = 1'b0;
        #1;
        chk("ab_wb1_rst", wb_1, 16'h0);
        chk("ab_rw1_rst", 16'(rw_1), 16'h0);
        chk("ab_ad1_rst", 16'(ad_1), 16'h0);
        chk("ab_wb3_rst", wb_3, 16'h0);
        nop(1);
        reset = 1'b1;
        nop(2);
        drive(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0, 3'd1);
        repeat (3) tick();
        chk("ab_ld_wb3", wb_3, 16'h1111);
        chk("ab_ld_rw3", 16'(rw_3), 16'h1);
        chk("ab_ld_ad3", 16'(ad_3), 16'h1);
        nop(2);

        // Both requests high behaves as a store.
        drive(1'b1, 1'b1, 1'b1, 16'h0040, 16'h5555, 3'd4);
        repeat (2) tick();
        chk("both_wb2", wb_2, 16'h0040);
        chk("both_rw2", 16'(rw_2), 16'h1);
        chk("both_ad2", 16'(ad_2), 16'h4);
        drive(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0, 3'd2);
        chk("both_st1", 16'(st_1), 16'h0);
        tick();
        chk("both_ld_wb1", wb_1, 16'h5555);
        tick();
        chk("both_ld_wb2", wb_2, 16'h5555);
        nop(2);

        // Out-of-range store: faults with the check, wraps to address 0 without it.
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0101, 3'd0);
        repeat (2) tick();
        nop(1);
        drive(1'b0, 1'b1, 1'b1, 16'h0800, 16'h7777, 3'd5);
        repeat (2) tick();
`ifdef MEM_RANGE_CHECK_EN
        chk("rng_fault2", 16'(fault_2), 16'h1);
        chk("rng_rw2", 16'(rw_2), 16'h0);
        chk("rng_wb2", wb_2, 16'h0);
`else
        chk("rng_wb2", wb_2, 16'h0800);
        chk("rng_rw2", 16'(rw_2), 16'h1);
`endif
        drive(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0, 3'd3);
        tick();
`ifdef MEM_RANGE_CHECK_EN
        chk("rng_fault2_clr", 16'(fault_2), 16'h0);
`endif
        tick();
`ifdef MEM_RANGE_CHECK_EN
        chk("rng_ld_wb2", wb_2, 16'h0101);
`else
        chk("rng_ld_wb2", wb_2, 16'h7777);
`endif
        nop(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
